// File: rtl/montgomery_mul_pipe.sv
// Montgomery modular multiplier: result = a*b*2^-WIDTH mod N (N odd).
// Scans DIGIT bits of a per cycle with unrolled radix-2 steps and applies
// one conditional subtraction to bring the accumulator into [0, N).
// Valid/ready on both sides; the result is held until the consumer accepts it.
`timescale 1ns/1ps

module montgomery_mul_pipe #(
    parameter int WIDTH = 256,
    parameter int DIGIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_N,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

    // Reject illegal digit sizes at elaboration time.
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8) || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("montgomery_mul_pipe: DIGIT must be 1/2/4/8 and divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, CALC, SUB, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] a_q, a_d;      // shifts right by DIGIT each CALC cycle
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH+1:0] m_q, m_d;      // accumulator: m < 2N plus headroom
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [WIDTH+2:0] t;
    logic [WIDTH+1:0] m_step;

    // DIGIT unrolled radix-2 Montgomery steps on the low bits of the shifted a.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, otherwise paths that skip an assignment infer a latch.
        t      = '0;
        m_step = m_q;
        for (int j = 0; j < DIGIT; j++) begin
            t = {1'b0, m_step} + (a_q[j] ? {3'b000, b_q} : '0);
            if (t[0]) begin
                t = t + {3'b000, n_q};
            end
            m_step = t[WIDTH+2:1];
        end
    end

    // Next-state and datapath update for the IDLE/CALC/SUB/DONE controller.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                // A flush in the same cycle wins; operands are not taken.
                if (i_valid && !i_flush) begin
                    n_d     = i_N;
                    a_d     = i_a;
                    b_d     = i_b;
                    m_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                m_d   = m_step;
                a_d   = a_q >> DIGIT;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                res_d   = (m_q >= {2'b00, n_q}) ? WIDTH'(m_q - {2'b00, n_q}) : m_q[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort: discard any partial or held result; res_q keeps its value.
        if (i_flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from values sampled at the same edge.
        if (i_rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign o_valid  = (state_q == DONE);
    assign o_busy   = (state_q != IDLE);
    assign o_ready  = (state_q == IDLE) && !i_rst;
    assign o_result = res_q;

endmodule

// File: tb/tb_montgomery_mul_pipe.sv
// Bench for montgomery_mul_pipe: two 8-bit instances (DIGIT 1 and 2) share one
// stimulus bus; a 256-bit DIGIT=4 instance runs random operands against a
// reference built from a full product and repeated halving modulo N.
`timescale 1ns/1ps

module tb_montgomery_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 8-bit bus shared by instances A (DIGIT=1) and B (DIGIT=2)
    logic       v8, f8, rdy8;
    logic [7:0] n8, a8, b8;
    logic       ora, ova, obsa;
    logic [7:0] resa;
    logic       orb, ovb, obsb;
    logic [7:0] resb;

    // 256-bit instance C (DIGIT=4)
    logic         v2, f2, rdy2;
    logic [255:0] n2, a2, b2;
    logic         or2, ov2, obs2;
    logic [255:0] res2;

    int checks = 0;
    int errors = 0;

    logic [7:0]   qa[$];
    logic [7:0]   qb[$];
    logic [255:0] q2[$];

    montgomery_mul_pipe #(.WIDTH(8), .DIGIT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(ora),
        .i_N(n8), .i_a(a8), .i_b(b8), .i_flush(f8),
        .o_valid(ova), .i_ready(rdy8), .o_result(resa), .o_busy(obsa)
    );

    montgomery_mul_pipe #(.WIDTH(8), .DIGIT(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(orb),
        .i_N(n8), .i_a(a8), .i_b(b8), .i_flush(f8),
        .o_valid(ovb), .i_ready(rdy8), .o_result(resb), .o_busy(obsb)
    );

    montgomery_mul_pipe #(.WIDTH(256), .DIGIT(4)) u_c (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(or2),
        .i_N(n2), .i_a(a2), .i_b(b2), .i_flush(f2),
        .o_valid(ov2), .i_ready(rdy2), .o_result(res2), .o_busy(obs2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: (a*b mod N) multiplied by inverse(2) = (N+1)/2, w times, mod N.
    function automatic logic [255:0] mont_ref(input logic [255:0] a, input logic [255:0] b,
                                              input logic [255:0] n, input int w);
        logic [511:0] p, nn, inv2;
        nn   = {256'd0, n};
        p    = ({256'd0, a} * {256'd0, b}) % nn;
        inv2 = (nn + 512'd1) >> 1;
        for (int i = 0; i < w; i++) p = (p * inv2) % nn;
        return p[255:0];
    endfunction

    function automatic logic [255:0] rand_below(input logic [255:0] n);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        r[255] = 1'b0;
        if (r >= n) r = r - n;
        return r;
    endfunction

    // Drive one 8-bit operand set; optionally record the expected result.
    task automatic start8(input logic [7:0] n, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input bit push);
        int k;
        k = 0;
        while (!ora && k < 50) begin tick(); k++; end
        checks++;
        if (ora !== 1'b1) begin
            errors++;
            $display("FAIL start8_ready got %b want 1", ora);
        end
        n8 = n; a8 = a; b8 = b; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        n8 = 8'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        if (push) begin
            qa.push_back(exp_res);
            qb.push_back(exp_res);
        end
    endtask

    // Wait (rdy8 low) until both 8-bit instances raise o_valid; report latencies.
    task automatic run_pair(output int la, output int lb);
        la = 0; lb = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ova && la == 0) la = k;
            if (ovb && lb == 0) lb = k;
            if (la != 0 && lb != 0) break;
        end
    endtask

    // Compare both held results against the scoreboard and consume them.
    task automatic consume8(input string name);
        logic [7:0] ea, eb;
        ea = qa.pop_front();
        eb = qb.pop_front();
        checks++;
        if (resa !== ea || ova !== 1'b1) begin
            errors++;
            $display("FAIL %s_a got %0d valid %b want %0d", name, resa, ova, ea);
        end
        checks++;
        if (resb !== eb || ovb !== 1'b1) begin
            errors++;
            $display("FAIL %s_b got %0d valid %b want %0d", name, resb, ovb, eb);
        end
        rdy8 = 1'b1;
        tick();
        rdy8 = 1'b0;
        checks++;
        if (ova !== 1'b0 || ovb !== 1'b0 || ora !== 1'b1) begin
            errors++;
            $display("FAIL %s_consumed got valid %b/%b ready %b want 0/0 1", name, ova, ovb, ora);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v8 = 0; f8 = 0; rdy8 = 0; n8 = 0; a8 = 0; b8 = 0;
        v2 = 0; f2 = 0; rdy2 = 0; n2 = 0; a2 = 0; b2 = 0;
        repeat (2) tick();
        checks++;
        if (ora !== 1'b0 || or2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_in_reset got %b/%b want 0/0", ora, or2);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ova !== 1'b0 || resa !== 8'd0 || obsa !== 1'b0 || ora !== 1'b1) begin
            errors++;
            $display("FAIL reset_a got v%b r%0d b%b rdy%b want v0 r0 b0 rdy1", ova, resa, obsa, ora);
        end
        checks++;
        if (ov2 !== 1'b0 || res2 !== 256'd0 || obs2 !== 1'b0 || or2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_c got v%b b%b rdy%b want v0 b0 rdy1", ov2, obs2, or2);
        end
    endtask

    task automatic test_basic();
        int la, lb;
        start8(8'd13, 8'd5, 8'd7, 8'd1, 1'b1);
        run_pair(la, lb);
        checks++;
        if (la != 9) begin errors++; $display("FAIL latency_d1 got %0d want 9", la); end
        checks++;
        if (lb != 5) begin errors++; $display("FAIL latency_d2 got %0d want 5", lb); end
        consume8("basic_5x7");
        start8(8'd13, 8'd12, 8'd12, 8'd3, 1'b1);
        run_pair(la, lb);
        consume8("square_12");
    endtask

    task automatic test_hold();
        int la, lb;
        start8(8'd13, 8'd0, 8'd12, 8'd0, 1'b1);
        run_pair(la, lb);
        for (int i = 0; i < 10; i++) begin
            n8 = 8'd13; a8 = 8'd5; b8 = 8'd7; v8 = 1'b1;   // must be ignored
            tick();
            checks++;
            if (ova !== 1'b1 || resa !== 8'd0 || ora !== 1'b0 || ovb !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d got v%b r%0d rdy%b vb%b want v1 r0 rdy0 vb1", i, ova, resa, ora, ovb);
            end
        end
        v8 = 1'b0;
        consume8("zero_a");
        repeat (2) tick();
        checks++;
        if (obsa !== 1'b0 || obsb !== 1'b0) begin
            errors++;
            $display("FAIL hold_ignored_valid got busy %b/%b want 0/0", obsa, obsb);
        end
    endtask

    task automatic test_flush();
        int la, lb, seen;
        // Flush during the third CALC cycle.
        start8(8'd13, 8'd5, 8'd7, 8'd0, 1'b0);
        tick(); tick();
        f8 = 1'b1;
        tick();
        f8 = 1'b0;
        checks++;
        if (obsa !== 1'b0 || ora !== 1'b1 || obsb !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc got busy %b rdy %b busyb %b want 0 1 0", obsa, ora, obsb);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ova || ovb) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_valid got %0d pulses want 0", seen); end
        // Flush together with i_valid in IDLE: nothing accepted.
        n8 = 8'd13; a8 = 8'd5; b8 = 8'd7; v8 = 1'b1; f8 = 1'b1;
        tick();
        v8 = 1'b0; f8 = 1'b0;
        checks++;
        if (obsa !== 1'b0 || obsb !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_valid got busy %b/%b want 0/0", obsa, obsb);
        end
        // Flush in DONE: valid drops, result value retained.
        start8(8'd13, 8'd5, 8'd7, 8'd0, 1'b0);
        run_pair(la, lb);
        f8 = 1'b1;
        tick();
        f8 = 1'b0;
        checks++;
        if (ova !== 1'b0 || resa !== 8'd1 || obsa !== 1'b0) begin
            errors++;
            $display("FAIL flush_done got v%b r%0d busy %b want v0 r1 busy0", ova, resa, obsa);
        end
        // Normal operation afterwards.
        start8(8'd13, 8'd5, 8'd7, 8'd1, 1'b1);
        run_pair(la, lb);
        checks++;
        if (la != 9 || lb != 5) begin
            errors++;
            $display("FAIL flush_after_latency got %0d/%0d want 9/5", la, lb);
        end
        consume8("after_flush");
    endtask

    task automatic test_reset_mid();
        int la, lb;
        start8(8'd13, 8'd12, 8'd12, 8'd0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ova !== 1'b0 || resa !== 8'd0 || obsa !== 1'b0 || ora !== 1'b1 || obsb !== 1'b0) begin
            errors++;
            $display("FAIL reset_calc got v%b r%0d busy%b rdy%b want v0 r0 busy0 rdy1", ova, resa, obsa, ora);
        end
        start8(8'd13, 8'd12, 8'd12, 8'd0, 1'b0);
        run_pair(la, lb);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ova !== 1'b0 || resa !== 8'd0 || obsa !== 1'b0 || ora !== 1'b1 || resb !== 8'd0 || ovb !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got v%b r%0d busy%b rdy%b rb%0d want v0 r0 busy0 rdy1 rb0",
                     ova, resa, obsa, ora, resb);
        end
    endtask

    // Back-to-back random 256-bit operations with i_ready held high.
    task automatic test_back_to_back();
        logic [255:0] nmod, ea, eb, exp_res;
        int lat, k;
        nmod = (256'd1 << 255) - 256'd19;
        rdy2 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            case (i)
                0:       begin ea = nmod - 256'd1; eb = nmod - 256'd1; end
                1:       begin ea = 256'd0;        eb = rand_below(nmod); end
                2:       begin ea = 256'd1;        eb = 256'd1; end
                default: begin ea = rand_below(nmod); eb = rand_below(nmod); end
            endcase
            k = 0;
            while (!or2 && k < 10) begin tick(); k++; end
            n2 = nmod; a2 = ea; b2 = eb; v2 = 1'b1;
            tick();
            v2 = 1'b0;
            a2 = rand_below(nmod); b2 = rand_below(nmod);
            q2.push_back(mont_ref(ea, eb, nmod, 256));
            lat = 0;
            while (!ov2 && lat < 100) begin tick(); lat++; end
            checks++;
            if (lat != 65) begin errors++; $display("FAIL w256_latency_%0d got %0d want 65", i, lat); end
            exp_res = q2.pop_front();
            checks++;
            if (res2 !== exp_res || ov2 !== 1'b1) begin
                errors++;
                $display("FAIL w256_result_%0d got %h want %h", i, res2, exp_res);
            end
            tick();   // consumed at this edge (i_ready high)
        end
        rdy2 = 1'b0;
        checks++;
        if (ov2 !== 1'b0 || obs2 !== 1'b0) begin
            errors++;
            $display("FAIL w256_drained got v%b busy%b want 0 0", ov2, obs2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
